// File: rtl/cache_mem_arbiter.sv
// Arbitrates the shared cacheline-adapter path between icache and dcache line requests.
// Dcache wins by default; a saturating starvation counter forces an icache grant.
module cache_mem_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned LINE_W       = 256,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              ca_read,
    output logic              ca_write,
    output logic [ADDR_W-1:0] ca_addr,
    output logic [LINE_W-1:0] ca_wdata,
    input  logic [LINE_W-1:0] ca_rdata,
    input  logic              ca_resp,
    output logic              busy
);

    localparam int unsigned      CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, SERV_I, SERV_D, RESP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  starve_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              wr_q;
    logic              serve_d_q;
    logic [LINE_W-1:0] i_rdata_q;
    logic [LINE_W-1:0] d_rdata_q;
    logic              d_pend;
    logic              grant_i;
    logic              grant_d;

    always_comb begin
        d_pend  = d_read | d_write;
        state_n = state;
        grant_i = 1'b0;
        grant_d = 1'b0;
        case (state)
            IDLE: begin
                if (d_pend && i_read && (starve_cnt == LIMIT)) begin
                    grant_i = 1'b1;
                    state_n = SERV_I;
                end else if (d_pend) begin
                    grant_d = 1'b1;
                    state_n = SERV_D;
                end else if (i_read) begin
                    grant_i = 1'b1;
                    state_n = SERV_I;
                end
            end
            SERV_I, SERV_D: begin
                if (ca_resp) state_n = RESP;
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_q       <= 1'b0;
            serve_d_q  <= 1'b0;
            i_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state <= state_n;
            if (grant_i) begin
                addr_q     <= i_addr;
                wr_q       <= 1'b0;
                serve_d_q  <= 1'b0;
                starve_cnt <= '0;
            end
            // A simultaneous read+write is taken as a writeback.
            if (grant_d) begin
                addr_q    <= d_addr;
                wdata_q   <= d_wdata;
                wr_q      <= d_write;
                serve_d_q <= 1'b1;
                if (!i_read) begin
                    starve_cnt <= '0;
                end else if (starve_cnt != LIMIT) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end
            if (ca_resp && (state == SERV_I)) i_rdata_q <= ca_rdata;
            if (ca_resp && (state == SERV_D) && !wr_q) d_rdata_q <= ca_rdata;
        end
    end

    assign ca_read  = (state == SERV_I) || ((state == SERV_D) && !wr_q);
    assign ca_write = (state == SERV_D) && wr_q;
    assign ca_addr  = addr_q;
    assign ca_wdata = wdata_q;
    assign i_resp   = (state == RESP) && !serve_d_q;
    assign d_resp   = (state == RESP) && serve_d_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected commands/responses are queued at stimulus
// time and checked by an independent monitor; a behavioural adapter answers commands.
module tb_cache_mem_arbiter;

    typedef struct {
        bit          is_d;
        bit          wr;
        logic [31:0] addr;
        logic [255:0] wdata;
        bit          gap_chk;
    } cmd_t;

    typedef struct {
        bit           is_d;
        logic [255:0] rdata;
    } rsp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_read;
    logic [31:0]  i_addr;
    logic [255:0] i_rdata;
    logic         i_resp;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic [255:0] d_rdata;
    logic         d_resp;
    logic         ca_read;
    logic         ca_write;
    logic [31:0]  ca_addr;
    logic [255:0] ca_wdata;
    logic [255:0] ca_rdata;
    logic         ca_resp;
    logic         busy;

    cmd_t         cmd_q[$];
    rsp_t         rsp_q[$];
    logic [255:0] ad_q[$];

    int checks = 0;
    int errors = 0;
    int lat    = 5;
    int d_left = 0;
    int d_idx  = 0;

    cache_mem_arbiter #(.ADDR_W(32), .LINE_W(256), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .ca_read(ca_read), .ca_write(ca_write), .ca_addr(ca_addr), .ca_wdata(ca_wdata),
        .ca_rdata(ca_rdata), .ca_resp(ca_resp), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input bit is_d, input bit wr, input logic [31:0] a,
                              input logic [255:0] wd, input logic [255:0] rd,
                              input logic [255:0] adata, input bit gap);
        cmd_t c;
        rsp_t r;
        c.is_d = is_d; c.wr = wr; c.addr = a; c.wdata = wd; c.gap_chk = gap;
        r.is_d = is_d; r.rdata = rd;
        cmd_q.push_back(c);
        rsp_q.push_back(r);
        ad_q.push_back(adata);
    endtask

    // Requesters: drop (or re-issue) in the cycle after their response pulse.
    task automatic step();
        @(negedge clk);
        if (i_resp) i_read = 1'b0;
        if (d_resp) begin
            if (d_left > 0) begin
                d_addr = 32'h1000 + 32'(d_idx * 32);
                d_idx++;
                d_left--;
            end else begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            step();
            if (rsp_q.size() == 0 && cmd_q.size() == 0 && !busy && !i_read && !d_read && !d_write)
                done = 1'b1;
        end
        chk(name, 256'(done), 256'd1);
    endtask

    // Behavioural cacheline adapter: answers lat cycles after a command appears.
    initial begin
        int cnt = 0;
        ca_resp  = 1'b0;
        ca_rdata = '0;
        forever begin
            @(negedge clk);
            if (!(ca_read || ca_write)) begin
                ca_resp = 1'b0;
                cnt     = 0;
            end else if (!ca_resp) begin
                cnt++;
                if (cnt >= lat) begin
                    ca_resp  = 1'b1;
                    ca_rdata = (ad_q.size() > 0) ? ad_q.pop_front() : '0;
                end
            end
        end
    end

    // Monitor: compares commands and responses against the queues.
    initial begin
        cmd_t cur;
        rsp_t r;
        bit   in_cmd = 1'b0;
        bit   cmd_now;
        int   cyc = 0;
        int   last_resp_cyc = -100;
        cur.is_d = 0; cur.wr = 0; cur.addr = '0; cur.wdata = '0; cur.gap_chk = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!reset) begin
                in_cmd = 1'b0;
                continue;
            end
            cmd_now = ca_read | ca_write;
            if (cmd_now && !in_cmd) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd", {ca_write, ca_read}, 2'b00);
                end else begin
                    cur = cmd_q.pop_front();
                    if (cur.gap_chk) chk("grant_gap", 256'(cyc - last_resp_cyc), 256'd2);
                    if (!cur.is_d) chk("starve_clr", 256'(dut.starve_cnt), 256'd0);
                end
            end
            if (cmd_now) begin
                chk("cmd_op", {ca_read, ca_write}, cur.wr ? 2'b01 : 2'b10);
                chk("cmd_addr", ca_addr, cur.addr);
                if (cur.wr) chk("cmd_wdata", ca_wdata, cur.wdata);
            end
            in_cmd = cmd_now;
            if (i_resp || d_resp) begin
                chk("resp_cmd_low", {i_resp & d_resp, ca_read, ca_write}, 3'b000);
                if (rsp_q.size() == 0) begin
                    chk("unexpected_resp", {i_resp, d_resp}, 2'b00);
                end else begin
                    r = rsp_q.pop_front();
                    chk("resp_who", {i_resp, d_resp}, r.is_d ? 2'b01 : 2'b10);
                    chk(r.is_d ? "d_rdata" : "i_rdata", r.is_d ? d_rdata : i_rdata, r.rdata);
                end
                last_resp_cyc = cyc;
            end
        end
    end

    initial begin
        logic [255:0] a5   = {32{8'hA5}};
        logic [255:0] dbf  = {8{32'hDEAD_BEEF}};
        logic [255:0] bad  = {8{32'h0BAD_F00D}};
        logic [255:0] wb   = {8{32'h1234_5678}};
        logic [255:0] junk = {8{32'hFFFF_0000}};
        logic [255:0] ifil = {8{32'h1111_2222}};
        logic [255:0] cafe = {8{32'hCAFE_F00D}};
        logic [255:0] dk;
        bit           idle_ok;

        reset = 1'b0; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
        d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {ca_read, ca_write, i_resp, d_resp, busy}, 5'b0);
        chk("rst_ca_addr", ca_addr, 32'h0);
        reset = 1'b1;
        step();

        // Lone icache miss
        expect_txn(1'b0, 1'b0, 32'h60, '0, a5, a5, 1'b0);
        i_read = 1'b1; i_addr = 32'h0000_0060;
        wait_done("to_lone_i", 100);

        // Simultaneous: dcache first, icache in the first IDLE after d_resp
        expect_txn(1'b1, 1'b0, 32'h100, '0, dbf, dbf, 1'b0);
        expect_txn(1'b0, 1'b0, 32'h80, '0, bad, bad, 1'b1);
        i_read = 1'b1; i_addr = 32'h80; d_read = 1'b1; d_addr = 32'h100;
        wait_done("to_simul", 100);

        // Writeback: wdata changed after grant must not reach ca_wdata; d_rdata unchanged
        expect_txn(1'b1, 1'b1, 32'h200, wb, dbf, junk, 1'b0);
        d_write = 1'b1; d_addr = 32'h200; d_wdata = wb;
        idle_ok = 1'b0;
        for (int n = 0; n < 20 && !idle_ok; n++) begin
            step();
            if (ca_write) idle_ok = 1'b1;
        end
        chk("wb_granted", 256'(idle_ok), 256'd1);
        d_wdata = ~wb; d_addr = 32'h7E0;
        wait_done("to_wb", 100);

        // Starvation: six back-to-back dcache misses with icache waiting -> D,D,D,D,I,D,D
        for (int k = 0; k < 6; k++) begin
            dk = {8{24'hD0D0D0, 8'(k)}};
            if (k == 4) expect_txn(1'b0, 1'b0, 32'h2000, '0, ifil, ifil, 1'b0);
            expect_txn(1'b1, 1'b0, 32'h1000 + 32'(k * 32), '0, dk, dk, 1'b0);
        end
        i_read = 1'b1; i_addr = 32'h2000;
        d_read = 1'b1; d_addr = 32'h1000; d_idx = 1; d_left = 5;
        wait_done("to_starve", 300);

        // Illegal read+write -> treated as one writeback
        dk = {8{24'hD0D0D0, 8'd5}};
        expect_txn(1'b1, 1'b1, 32'h400, cafe, dk, junk, 1'b0);
        d_read = 1'b1; d_write = 1'b1; d_addr = 32'h400; d_wdata = cafe;
        wait_done("to_illegal", 100);

        // Reset mid-SERV_D: no response, outputs clear immediately
        lat = 20;
        begin
            cmd_t c;
            c.is_d = 1'b1; c.wr = 1'b0; c.addr = 32'h300; c.wdata = '0; c.gap_chk = 1'b0;
            cmd_q.push_back(c);
        end
        d_read = 1'b1; d_addr = 32'h300;
        repeat (6) step();
        chk("mid_busy", 256'(busy), 256'd1);
        #2;
        reset = 1'b0; d_read = 1'b0;
        #1;
        chk("mid_rst_ctrl", {ca_read, ca_write, i_resp, d_resp, busy}, 5'b0);
        chk("mid_rst_addr", ca_addr, 32'h0);
        chk("mid_rst_wdata", ca_wdata, '0);
        chk("mid_rst_irdata", i_rdata, '0);
        chk("mid_rst_drdata", d_rdata, '0);
        repeat (2) step();
        reset = 1'b1;
        idle_ok = 1'b1;
        for (int n = 0; n < 12; n++) begin
            step();
            if (busy || ca_read || ca_write || i_resp || d_resp) idle_ok = 1'b0;
        end
        chk("idle_after_rst", 256'(idle_ok), 256'd1);
        chk("cmd_q_empty", 256'(cmd_q.size()), 256'd0);
        chk("rsp_q_empty", 256'(rsp_q.size()), 256'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single burst-memory path (cacheline adapter, 256-bit lines) between the instruction cache and data cache miss/writeback requests in mp4.
- Dcache has priority, because its request belongs to an older instruction sitting in MEM.
- A starvation counter guarantees forward progress for instruction fetch.
- Grants are registered: one outstanding line transaction at a time, with address/data latched at grant.

Parameters:
ADDR_W, 32, address width
LINE_W, 256, cacheline width in bits
STARVE_LIMIT, 4, consecutive dcache grants allowed while icache waits before icache is forced

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
i_read  in  1  icache line read request, held until i_resp
i_addr  in  ADDR_W  icache line address (bits [4:0] zero)
i_rdata  out  LINE_W  line returned to icache
i_resp  out  1  one-cycle completion pulse to icache
d_read  in  1  dcache line read request, held until d_resp
d_write  in  1  dcache line writeback request, held until d_resp
d_addr  in  ADDR_W  dcache line address
d_wdata  in  LINE_W  writeback line
d_rdata  out  LINE_W  line returned to dcache
d_resp  out  1  one-cycle completion pulse to dcache
ca_read  out  1  read command to cacheline adapter
ca_write  out  1  write command to cacheline adapter
ca_addr  out  ADDR_W  latched line address
ca_wdata  out  LINE_W  latched writeback line
ca_rdata  in  LINE_W  line from adapter, valid with ca_resp
ca_resp  in  1  adapter completion pulse
busy  out  1  high in any state other than IDLE (for perf counters)

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE and starve_cnt to 0.
  - All outputs go to 0: ca_*, i_rdata, d_rdata, i_resp, d_resp, busy.
  - A reset arriving mid-transaction abandons it; no resp is issued.
- States:
  - IDLE: evaluates requests.
  - SERV_I: ca_read=1.
  - SERV_D: ca_read=d_read_lat or ca_write=d_write_lat.
  - RESP: one-cycle response pulse, then back to IDLE.
- Grant rule in IDLE (first match wins):
  - d pending and i_read and starve_cnt==STARVE_LIMIT -> SERV_I.
  - d pending -> SERV_D.
  - i_read -> SERV_I.
  - else stay in IDLE.
  - "d pending" means d_read|d_write.
- At grant: ca_addr, ca_wdata and the op type are latched. Downstream outputs are driven only from the latched registers and stay stable until ca_resp. Requester input changes after grant are ignored.
- d_read and d_write both high: illegal. The arbiter treats it as a write (writeback before fill).
- Starvation counter (width clog2(STARVE_LIMIT+1)):
  - On a dcache grant with i_read=1: increment, saturating at STARVE_LIMIT.
  - On a dcache grant with i_read=0: clear.
  - On an icache grant: clear.
- Timing, with the grant decision in cycle 0:
  - cycle 1: command asserted.
  - Adapter returns ca_resp in cycle N: the arbiter captures ca_rdata into i_rdata or d_rdata and enters RESP.
  - cycle N+1: exactly one of i_resp/d_resp is high for one cycle. ca_read/ca_write are low from N+1 onward.
  - cycle N+2: back in IDLE. The earliest next grant decision is in N+2, with the command in N+3.
- Requesters drop their request in the cycle after resp. Requests seen in the RESP state are never granted.
- rdata outputs hold their last captured value until the next capture for that requester.
- d_rdata is not updated on writeback completion; only d_resp pulses.
- A ca_resp outside SERV_I/SERV_D is ignored.

Test Plan:
- Reset and idle: assert reset=0 mid-SERV_D.
  - Outputs are 0 immediately, with no resp.
  - After release with no requests, busy=0 and ca_read=ca_write=0 indefinitely.
- Lone icache miss: i_read=1, i_addr=0x0000_0060; adapter responds 5 cycles after ca_read with rdata=256'hA5...A5.
  - ca_addr=0x60.
  - i_resp pulses one cycle after ca_resp, with i_rdata=A5...A5.
  - d_resp stays 0.
- Simultaneous requests: i_read and d_read asserted in the same cycle, d_addr=0x100.
  - Dcache is served first with ca_addr=0x100.
  - Icache is granted in the first IDLE after d_resp.
- Writeback: d_write=1, d_addr=0x200, d_wdata=256'h1234_5678 repeated.
  - ca_write=1 with the latched data.
  - Changing d_wdata after grant does not alter ca_wdata.
  - d_resp pulses; d_rdata is unchanged.
- Starvation: i_read held high while dcache issues 6 back-to-back misses, STARVE_LIMIT=4.
  - Grant order is D,D,D,D,I,D,D.
  - starve_cnt is cleared on the icache grant.
- Illegal op: d_read=d_write=1 -> ca_write=1, ca_read=0, and exactly one d_resp.
